// File: rtl/uart_pixel_packetizer.sv
// Frames pixel words into sync/seq/payload/checksum byte packets for the UART byte-write port.
// Each pixel goes out big-endian as 16 bits; the checksum is the 8-bit sum of the seq byte and the payload bytes.
module uart_pixel_packetizer #(
  parameter int unsigned PixelWidth      = 12,
  parameter int unsigned PixelsPerPacket = 64,
  parameter logic [7:0]  Sync0           = 8'hA5,
  parameter logic [7:0]  Sync1           = 8'h5A
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_pixel_valid,
  input  logic [PixelWidth-1:0] i_pixel,
  output logic                  o_pixel_ready,
  output logic                  o_byte_valid,
  output logic [7:0]            o_byte,
  input  logic                  i_byte_ready,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, SEQ, WAIT_PIX, PIX_HI, PIX_LO, CSUM
  } state_t;

  localparam logic [15:0] LastPix = 16'(PixelsPerPacket - 1);

  state_t      state, state_next;
  logic [7:0]  seq, seq_next;
  logic [7:0]  csum, csum_next;
  logic [7:0]  pix_lo, pix_lo_next;
  logic [15:0] pix_cnt, pix_cnt_next;
  logic [7:0]  byte_next;
  logic        byte_valid_next;

  logic [15:0] pix_ext;
  logic [7:0]  csum_add;
  logic        xfer;
  logic        accept;

  assign pix_ext  = 16'(i_pixel);
  assign xfer     = o_byte_valid && i_byte_ready;
  assign accept   = o_pixel_ready && i_pixel_valid;
  assign csum_add = csum + o_byte;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      seq          <= '0;
      csum         <= '0;
      pix_lo       <= '0;
      pix_cnt      <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so register order is irrelevant.
      state        <= state_next;
      seq          <= seq_next;
      csum         <= csum_next;
      pix_lo       <= pix_lo_next;
      pix_cnt      <= pix_cnt_next;
      o_byte       <= byte_next;
      o_byte_valid <= byte_valid_next;
    end
  end

  // Next-state and next-datapath decode; the next byte is loaded on the same edge as a transfer.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can leave a value unassigned and infer a latch.
    state_next      = state;
    seq_next        = seq;
    csum_next       = csum;
    pix_lo_next     = pix_lo;
    pix_cnt_next    = pix_cnt;
    byte_next       = o_byte;
    byte_valid_next = o_byte_valid;

    unique case (state)
      IDLE: begin
        if (i_pixel_valid) begin
          state_next      = HDR0;
          byte_next       = Sync0;
          byte_valid_next = 1'b1;
          csum_next       = '0;
        end
      end
      HDR0: begin
        if (xfer) begin
          state_next = HDR1;
          byte_next  = Sync1;
        end
      end
      HDR1: begin
        if (xfer) begin
          state_next = SEQ;
          byte_next  = seq;
        end
      end
      SEQ: begin
        if (xfer) begin
          state_next      = WAIT_PIX;
          csum_next       = csum_add;
          byte_valid_next = 1'b0;
        end
      end
      WAIT_PIX: begin
        if (accept) begin
          state_next      = PIX_HI;
          byte_next       = pix_ext[15:8];
          pix_lo_next     = pix_ext[7:0];
          byte_valid_next = 1'b1;
        end
      end
      PIX_HI: begin
        if (xfer) begin
          state_next = PIX_LO;
          byte_next  = pix_lo;
          csum_next  = csum_add;
        end
      end
      PIX_LO: begin
        if (xfer) begin
          csum_next = csum_add;
          if (pix_cnt == LastPix) begin
            // The checksum byte must already include this low byte.
            state_next = CSUM;
            byte_next  = csum_add;
          end else begin
            state_next      = WAIT_PIX;
            pix_cnt_next    = pix_cnt + 16'd1;
            byte_valid_next = 1'b0;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_next      = IDLE;
          seq_next        = seq + 8'd1;
          csum_next       = '0;
          pix_cnt_next    = '0;
          byte_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    o_pixel_ready = (state == WAIT_PIX);
    o_busy        = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_pixel_packetizer.sv
// Bench for uart_pixel_packetizer: two instances (12-bit x2 pixels, 8-bit x1 pixel) checked against a byte-queue packet model.
module tb_uart_pixel_packetizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_pv, a_rdy, a_pready, a_bv, a_busy;
  logic [11:0] a_px;
  logic [7:0]  a_byte;

  logic        b_pv, b_rdy, b_pready, b_bv, b_busy;
  logic [7:0]  b_px;
  logic [7:0]  b_byte;

  uart_pixel_packetizer #(.PixelWidth(12), .PixelsPerPacket(2)) dut_a (
    .CLK(clk), .RST(rst_n),
    .i_pixel_valid(a_pv), .i_pixel(a_px), .o_pixel_ready(a_pready),
    .o_byte_valid(a_bv), .o_byte(a_byte), .i_byte_ready(a_rdy), .o_busy(a_busy)
  );

  uart_pixel_packetizer #(.PixelWidth(8), .PixelsPerPacket(1)) dut_b (
    .CLK(clk), .RST(rst_n),
    .i_pixel_valid(b_pv), .i_pixel(b_px), .o_pixel_ready(b_pready),
    .o_byte_valid(b_bv), .o_byte(b_byte), .i_byte_ready(b_rdy), .o_busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int seq_a = 0;
  int seq_b = 0;

  logic       a_stall = 1'b0, b_stall = 1'b0;
  logic [7:0] a_hold = '0, b_hold = '0;
  logic       xf_a, xf_b, acc_a, acc_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference packet: sync, seq, 16-bit big-endian pixels, (seq + payload bytes) mod 256.
  task automatic model_a(input int p0, input int p1);
    int sum;
    sum = seq_a + p0 / 256 + p0 % 256 + p1 / 256 + p1 % 256;
    exp_a.push_back(8'hA5);
    exp_a.push_back(8'h5A);
    exp_a.push_back(8'(seq_a));
    exp_a.push_back(8'(p0 / 256));
    exp_a.push_back(8'(p0 % 256));
    exp_a.push_back(8'(p1 / 256));
    exp_a.push_back(8'(p1 % 256));
    exp_a.push_back(8'(sum % 256));
    seq_a = (seq_a + 1) % 256;
  endtask

  task automatic model_b(input int p);
    exp_b.push_back(8'hA5);
    exp_b.push_back(8'h5A);
    exp_b.push_back(8'(seq_b));
    exp_b.push_back(8'h00);
    exp_b.push_back(8'(p));
    exp_b.push_back(8'((seq_b + p) % 256));
    seq_b = (seq_b + 1) % 256;
  endtask

  // Called at a negedge with inputs already driven: scores the transfers of the coming posedge, then advances.
  task automatic tick();
    if (a_stall) begin
      check("a_stall_valid", 32'(a_bv), 32'd1);
      check("a_stall_byte", 32'(a_byte), 32'(a_hold));
    end
    if (b_stall) begin
      check("b_stall_valid", 32'(b_bv), 32'd1);
      check("b_stall_byte", 32'(b_byte), 32'(b_hold));
    end
    xf_a  = rst_n && a_bv && a_rdy;
    xf_b  = rst_n && b_bv && b_rdy;
    acc_a = rst_n && a_pready && a_pv;
    acc_b = rst_n && b_pready && b_pv;
    if (xf_a) begin
      checks++;
      assert (exp_a.size() != 0) else begin
        errors++;
        $error("FAIL a_extra_byte: observed %0h expected no transfer", a_byte);
      end
      if (exp_a.size() != 0) check("a_byte", 32'(a_byte), 32'(exp_a.pop_front()));
    end
    if (xf_b) begin
      checks++;
      assert (exp_b.size() != 0) else begin
        errors++;
        $error("FAIL b_extra_byte: observed %0h expected no transfer", b_byte);
      end
      if (exp_b.size() != 0) check("b_byte", 32'(b_byte), 32'(exp_b.pop_front()));
    end
    a_stall = rst_n && a_bv && !a_rdy;
    b_stall = rst_n && b_bv && !b_rdy;
    a_hold  = a_byte;
    b_hold  = b_byte;
    @(negedge clk);
  endtask

  task automatic run_packet_a(input bit fixed, input bit rand_rdy, input bit starve, input bit stall0a);
    int  px[2];
    int  idx, nxf, cyc, starve_n, stall_n;
    bit  done;
    if (fixed) begin
      px[0] = 'h123;
      px[1] = 'hABC;
    end else begin
      for (int i = 0; i < 2; i++) px[i] = int'($urandom_range(0, 4095));
    end
    model_a(px[0], px[1]);
    idx = 0; nxf = 0; cyc = 0; starve_n = 0; stall_n = 0; done = 1'b0;
    while (!done && cyc < 2000) begin
      a_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      a_pv  = (idx < 2) && (!rand_rdy || $urandom_range(0, 3) != 0);
      a_px  = 12'(px[(idx < 2) ? idx : 1]);
      if (starve && nxf == 3 && idx == 0 && starve_n < 10) begin
        a_pv = 1'b0;
        starve_n++;
        check("starve_pixel_ready", 32'(a_pready), 32'd1);
        check("starve_byte_valid", 32'(a_bv), 32'd0);
      end
      if (stall0a && a_bv === 1'b1 && a_byte === 8'h0A && stall_n < 5) begin
        a_rdy = 1'b0;
        stall_n++;
      end
      tick();
      if (acc_a) idx++;
      if (xf_a) nxf++;
      cyc++;
      done = (idx == 2) && (exp_a.size() == 0) && (a_busy === 1'b0);
    end
    a_pv  = 1'b0;
    a_rdy = 1'b1;
    check("a_packet_done", 32'(done), 32'd1);
    check("a_byte_count", 32'(nxf), 32'd8);
    check("a_idle_valid", 32'(a_bv), 32'd0);
    if (starve)  check("starve_cycles", 32'(starve_n), 32'd10);
    if (stall0a) check("stall_cycles", 32'(stall_n), 32'd5);
  endtask

  task automatic run_packet_b(input int p, input bit rand_rdy);
    int idx, nxf, cyc;
    bit done;
    model_b(p);
    idx = 0; nxf = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 500) begin
      b_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      b_pv  = (idx < 1);
      b_px  = 8'(p);
      tick();
      if (acc_b) idx++;
      if (xf_b) nxf++;
      cyc++;
      done = (idx == 1) && (exp_b.size() == 0) && (b_busy === 1'b0);
    end
    b_pv  = 1'b0;
    b_rdy = 1'b1;
    check("b_packet_done", 32'(done), 32'd1);
    check("b_byte_count", 32'(nxf), 32'd6);
  endtask

  // Drive a packet into PIX_LO, pulse reset there, and confirm the abandoned packet leaves no trace.
  task automatic reset_mid_a();
    int px0, px1, idx, nxf, cyc;
    px0 = int'($urandom_range(0, 4095));
    px1 = int'($urandom_range(0, 4095));
    model_a(px0, px1);
    idx = 0; nxf = 0; cyc = 0;
    while (!(nxf == 4 && a_bv === 1'b1) && cyc < 200) begin
      a_rdy = 1'b1;
      a_pv  = (idx < 2);
      a_px  = 12'((idx == 0) ? px0 : px1);
      tick();
      if (acc_a) idx++;
      if (xf_a) nxf++;
      cyc++;
    end
    check("rst_reached_pix_lo", 32'(nxf), 32'd4);
    rst_n = 1'b0;
    a_pv  = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_valid", 32'(a_bv), 32'd0);
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_byte", 32'(a_byte), 32'h00);
    check("rst_mid_pixel_ready", 32'(a_pready), 32'd0);
    exp_a.delete();
    seq_a = 0;
    seq_b = 0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_pv = 1'b0; a_rdy = 1'b1; a_px = '0;
    b_pv = 1'b0; b_rdy = 1'b1; b_px = '0;
    @(negedge clk);
    tick();
    tick();
    check("rst_a_valid", 32'(a_bv), 32'd0);
    check("rst_a_byte", 32'(a_byte), 32'h00);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_pixel_ready", 32'(a_pready), 32'd0);
    check("rst_b_valid", 32'(b_bv), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-extension: 8-bit pixel FF, seq 0 gives A5 5A 00 00 FF FF.
    run_packet_b(255, 1'b0);
    for (int i = 0; i < 4; i++) run_packet_b(int'($urandom_range(0, 255)), 1'b1);

    // Basic packet: 123, ABC at seq 0 gives A5 5A 00 01 23 0A BC EA.
    run_packet_a(1'b1, 1'b0, 1'b0, 1'b0);
    // Backpressure on the 0A byte.
    run_packet_a(1'b1, 1'b0, 1'b0, 1'b1);
    // Pixel starvation after the SEQ byte.
    run_packet_a(1'b0, 1'b0, 1'b1, 1'b0);

    reset_mid_a();
    run_packet_a(1'b0, 1'b0, 1'b0, 1'b0);
    run_packet_b(int'($urandom_range(0, 255)), 1'b0);

    // Sequence number wraps through FF to 00 under random handshakes.
    for (int i = 0; i < 257; i++) run_packet_a(1'b0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
